// File: rtl/etc_pkg.sv
// Shared ETC2 definitions: mode encodings, packed colour type and 6/7-bit channel expansion.
package etc_pkg;

  typedef enum logic [2:0] {
    MODE_INDIV  = 3'd0,
    MODE_DIFF   = 3'd1,
    MODE_T      = 3'd2,
    MODE_H      = 3'd3,
    MODE_PLANAR = 3'd4
  } etc_mode_e;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } etc_rgb_t;

  function automatic logic [7:0] expand6(input logic [5:0] x);
    return {x, x[5:4]};
  endfunction

  function automatic logic [7:0] expand7(input logic [6:0] x);
    return {x, x[6]};
  endfunction

endpackage

// File: rtl/etc_planar_pixel_pipe_if.sv
// Request/response bundle between the block fetch stage, the planar pipe and the texel writer.
interface etc_planar_pixel_pipe_if;
  import etc_pkg::*;

  logic [63:0] block;
  logic        flags;
  logic        mode_rtr;
  logic [3:0]  pixIdx;
  logic        aplha;

  logic [2:0]  mode;
  logic        mode_rts;
  logic        color_rts;
  etc_rgb_t    baseColor_0;
  etc_rgb_t    baseColor_1;
  etc_rgb_t    baseColor_2;
  logic        pix_rts;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic [7:0]  a;

  modport master (
    output block, flags, mode_rtr, pixIdx, aplha,
    input  mode, mode_rts, color_rts, baseColor_0, baseColor_1, baseColor_2,
    input  pix_rts, r, g, b, a
  );

  modport slave (
    input  block, flags, mode_rtr, pixIdx, aplha,
    output mode, mode_rts, color_rts, baseColor_0, baseColor_1, baseColor_2,
    output pix_rts, r, g, b, a
  );

endinterface

// File: rtl/etc_planar_pixel_gen.sv
// Planar texel stage: bilinear extrapolation from O/H/V per channel, clamp to 8 bits, alpha fill.
module etc_planar_pixel_gen
  import etc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [3:0] i_pix_idx,
  input  logic       i_alpha,
  input  etc_rgb_t   i_base_o,
  input  etc_rgb_t   i_base_h,
  input  etc_rgb_t   i_base_v,
  output logic       o_valid,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b,
  output logic [7:0] o_a
);

  // 12-bit signed covers -508..1532, the full reachable range of the weighted sum.
  function automatic logic [7:0] interp(input logic [7:0] o, input logic [7:0] h,
                                        input logic [7:0] v, input logic [1:0] x,
                                        input logic [1:0] y);
    logic signed [11:0] sum;
    logic signed [11:0] q;
    sum = $signed({10'd0, x}) * ($signed({4'd0, h}) - $signed({4'd0, o}))
        + $signed({10'd0, y}) * ($signed({4'd0, v}) - $signed({4'd0, o}))
        + $signed({2'd0, o, 2'd0}) + 12'sd2;
    q = sum >>> 2;
    if (q[11]) return 8'h00;
    if (|q[10:8]) return 8'hFF;
    return q[7:0];
  endfunction

  logic [1:0] w_x;
  logic [1:0] w_y;
  logic       r_valid;
  logic [7:0] r_r;
  logic [7:0] r_g;
  logic [7:0] r_b;
  logic [7:0] r_a;

  assign w_x = i_pix_idx[3:2];
  assign w_y = i_pix_idx[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_r     <= 8'h00;
      r_g     <= 8'h00;
      r_b     <= 8'h00;
      r_a     <= 8'h00;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_r <= interp(i_base_o.r, i_base_h.r, i_base_v.r, w_x, w_y);
        r_g <= interp(i_base_o.g, i_base_h.g, i_base_v.g, w_x, w_y);
        r_b <= interp(i_base_o.b, i_base_h.b, i_base_v.b, w_x, w_y);
        r_a <= i_alpha ? 8'hFF : 8'h00;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_r     = r_r;
  assign o_g     = r_g;
  assign o_b     = r_b;
  assign o_a     = r_a;

endmodule

// File: rtl/etc_planar_pixel_pipe.sv
// ETC2 RGB front-end: mode classify, planar base-colour decode, texel interpolate (3 stages).
// Define ETC_PUNCHTHROUGH_EN to honour the RGBA1 punch-through flag during mode detection.
module etc_planar_pixel_pipe
  import etc_pkg::*;
(
  input logic                    sclk,
  input logic                    rsrt,
  etc_planar_pixel_pipe_if.slave io_bus
);

  logic [63:0] w_blk;
  logic        w_diff;
  logic [6:0]  w_rsum;
  logic [6:0]  w_gsum;
  logic [6:0]  w_bsum;
  etc_mode_e   w_mode;
  etc_rgb_t    w_base_o;
  etc_rgb_t    w_base_h;
  etc_rgb_t    w_base_v;
  logic        w_planar;
  logic        w_pix_rts;
  logic [7:0]  w_r;
  logic [7:0]  w_g;
  logic [7:0]  w_b;
  logic [7:0]  w_a;

  etc_mode_e   r_mode;
  logic        r_mode_rts;
  logic        r_color_rts;
  etc_rgb_t    r_base_o;
  etc_rgb_t    r_base_h;
  etc_rgb_t    r_base_v;

  assign w_blk = io_bus.block;

`ifdef ETC_PUNCHTHROUGH_EN
  // In RGBA1 blocks bit 33 is the opaque flag, so the differential family always applies.
  assign w_diff = w_blk[33] | io_bus.flags;
`else
  logic w_unused_flags;
  assign w_unused_flags = io_bus.flags;
  assign w_diff = w_blk[33];
`endif

  // Base + sign-extended delta, mod 128: negatives wrap above 31, so one compare catches both.
  assign w_rsum = {2'b00, w_blk[63:59]} + {{4{w_blk[58]}}, w_blk[58:56]};
  assign w_gsum = {2'b00, w_blk[55:51]} + {{4{w_blk[50]}}, w_blk[50:48]};
  assign w_bsum = {2'b00, w_blk[47:43]} + {{4{w_blk[42]}}, w_blk[42:40]};

  always_comb begin
    w_mode = MODE_DIFF;
    if (!w_diff)                w_mode = MODE_INDIV;
    else if (w_rsum > 7'd31)    w_mode = MODE_T;
    else if (w_gsum > 7'd31)    w_mode = MODE_H;
    else if (w_bsum > 7'd31)    w_mode = MODE_PLANAR;
  end

  assign w_base_o = {expand6({w_blk[48], w_blk[44:43], w_blk[41:39]}),
                     expand7({w_blk[56], w_blk[54:49]}),
                     expand6(w_blk[62:57])};
  assign w_base_h = {expand6(w_blk[24:19]), expand7(w_blk[31:25]),
                     expand6({w_blk[38:34], w_blk[32]})};
  assign w_base_v = {expand6(w_blk[5:0]), expand7(w_blk[12:6]), expand6(w_blk[18:13])};

  always_ff @(posedge sclk) begin
    if (rsrt) begin
      r_mode_rts <= 1'b0;
      r_mode     <= MODE_INDIV;
    end else begin
      r_mode_rts <= io_bus.mode_rtr;
      if (io_bus.mode_rtr) r_mode <= w_mode;
    end
  end

  assign w_planar = r_mode_rts && (r_mode == MODE_PLANAR);

  // Base colours hold across non-planar blocks; the block word is still stable here.
  always_ff @(posedge sclk) begin
    if (rsrt) begin
      r_color_rts <= 1'b0;
      r_base_o    <= '0;
      r_base_h    <= '0;
      r_base_v    <= '0;
    end else begin
      r_color_rts <= w_planar;
      if (w_planar) begin
        r_base_o <= w_base_o;
        r_base_h <= w_base_h;
        r_base_v <= w_base_v;
      end
    end
  end

  etc_planar_pixel_gen u_pixel_gen (
    .i_clk     (sclk),
    .i_rst     (rsrt),
    .i_valid   (r_color_rts),
    .i_pix_idx (io_bus.pixIdx),
    .i_alpha   (io_bus.aplha),
    .i_base_o  (r_base_o),
    .i_base_h  (r_base_h),
    .i_base_v  (r_base_v),
    .o_valid   (w_pix_rts),
    .o_r       (w_r),
    .o_g       (w_g),
    .o_b       (w_b),
    .o_a       (w_a)
  );

  assign io_bus.mode        = r_mode;
  assign io_bus.mode_rts    = r_mode_rts;
  assign io_bus.color_rts   = r_color_rts;
  assign io_bus.baseColor_0 = r_base_o;
  assign io_bus.baseColor_1 = r_base_h;
  assign io_bus.baseColor_2 = r_base_v;
  assign io_bus.pix_rts     = w_pix_rts;
  assign io_bus.r           = w_r;
  assign io_bus.g           = w_g;
  assign io_bus.b           = w_b;
  assign io_bus.a           = w_a;

endmodule

// File: tb/tb_etc_planar_pixel_pipe.sv
// Scoreboard bench for etc_planar_pixel_pipe: directed blocks push expectations, a monitor pops.
module tb_etc_planar_pixel_pipe;

  localparam logic [63:0] BLK_A   = 64'h5F93046AA31D701B;
  localparam logic [71:0] COL_A   = {24'h8293BE, 24'h8EA3D3, 24'h6D81AE};
  localparam logic [63:0] BLK_C   = 64'h7E000402FE001FC0;
  localparam logic [71:0] COL_C   = {24'h0000FF, 24'h00FF00, 24'h00FF00};
  localparam logic [63:0] BLK_IND = 64'h0000000000000000;
  localparam logic [63:0] BLK_T   = 64'hF900000200000000;
  localparam logic [63:0] BLK_H   = 64'h0007000200000000;
  localparam logic [63:0] BLK_D   = 64'h0000000200000000;

  logic sclk = 1'b0;
  logic rsrt;
  int   checks = 0;
  int   errors = 0;

  logic [2:0]  mode_q[$];
  logic [71:0] color_q[$];
  logic [31:0] pix_q[$];

  always #5 sclk = ~sclk;

  etc_planar_pixel_pipe_if bus_if ();

  etc_planar_pixel_pipe dut (
    .sclk   (sclk),
    .rsrt   (rsrt),
    .io_bus (bus_if)
  );

  function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endfunction

  function automatic void spurious(input string name);
    checks++;
    errors++;
    $display("FAIL %s: valid asserted with no expected item queued", name);
  endfunction

  always @(negedge sclk) begin
    if (bus_if.mode_rts === 1'b1) begin
      if (mode_q.size() == 0) spurious("mode");
      else chk("mode", 72'(bus_if.mode), 72'(mode_q.pop_front()));
    end
    if (bus_if.color_rts === 1'b1) begin
      if (color_q.size() == 0) spurious("base_colors");
      else chk("base_colors", {bus_if.baseColor_0, bus_if.baseColor_1, bus_if.baseColor_2},
               color_q.pop_front());
    end
    if (bus_if.pix_rts === 1'b1) begin
      if (pix_q.size() == 0) spurious("texel");
      else chk("texel_rgba", 72'({bus_if.r, bus_if.g, bus_if.b, bus_if.a}),
               72'(pix_q.pop_front()));
    end
  end

  task automatic issue(input logic [63:0] blk, input logic fl, input logic [3:0] idx,
                       input logic al, input logic [2:0] m, input logic [71:0] col,
                       input logic [31:0] pix);
    bus_if.block    = blk;
    bus_if.flags    = fl;
    bus_if.pixIdx   = idx;
    bus_if.aplha    = al;
    bus_if.mode_rtr = 1'b1;
    mode_q.push_back(m);
    if (m == 3'd4) begin
      color_q.push_back(col);
      pix_q.push_back(pix);
    end
    @(posedge sclk);
    #1;
    bus_if.mode_rtr = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_mode_rts"}, 72'(bus_if.mode_rts), 72'd0);
    chk({tag, "_color_rts"}, 72'(bus_if.color_rts), 72'd0);
    chk({tag, "_pix_rts"}, 72'(bus_if.pix_rts), 72'd0);
    chk({tag, "_mode"}, 72'(bus_if.mode), 72'd0);
    chk({tag, "_base0"}, 72'(bus_if.baseColor_0), 72'd0);
    chk({tag, "_base1"}, 72'(bus_if.baseColor_1), 72'd0);
    chk({tag, "_base2"}, 72'(bus_if.baseColor_2), 72'd0);
    chk({tag, "_rgba"}, 72'({bus_if.r, bus_if.g, bus_if.b, bus_if.a}), 72'd0);
  endtask

  initial begin
    rsrt            = 1'b1;
    bus_if.block    = '0;
    bus_if.flags    = 1'b0;
    bus_if.mode_rtr = 1'b0;
    bus_if.pixIdx   = 4'd0;
    bus_if.aplha    = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    rsrt = 1'b0;
    check_idle("reset");

    // Reference planar block at three texel positions.
    issue(BLK_A, 1'b0, 4'd0, 1'b1, 3'd4, COL_A, {8'd190, 8'd147, 8'd130, 8'hFF});
    issue(BLK_A, 1'b0, 4'd1, 1'b1, 3'd4, COL_A, {8'd186, 8'd143, 8'd125, 8'hFF});
    issue(BLK_A, 1'b0, 4'd15, 1'b1, 3'd4, COL_A, {8'd194, 8'd146, 8'd123, 8'hFF});

    // Non-planar classification only.
    issue(BLK_IND, 1'b0, 4'd0, 1'b1, 3'd0, '0, '0);
    issue(BLK_T, 1'b0, 4'd0, 1'b1, 3'd2, '0, '0);
    issue(BLK_H, 1'b0, 4'd0, 1'b1, 3'd3, '0, '0);
    issue(BLK_D, 1'b0, 4'd0, 1'b1, 3'd1, '0, '0);

    // Clamp: red sum goes negative, green exceeds 1023 at (3,3).
    issue(BLK_C, 1'b0, 4'd15, 1'b0, 3'd4, COL_C, {8'd0, 8'd255, 8'd0, 8'h00});
    issue(BLK_C, 1'b0, 4'd0, 1'b1, 3'd4, COL_C, {8'd255, 8'd0, 8'd0, 8'hFF});

`ifdef ETC_PUNCHTHROUGH_EN
    issue(BLK_IND, 1'b1, 4'd0, 1'b1, 3'd1, '0, '0);
`else
    issue(BLK_IND, 1'b1, 4'd0, 1'b1, 3'd0, '0, '0);
`endif

    // Back-to-back requests, one per cycle.
    bus_if.block    = BLK_A;
    bus_if.flags    = 1'b0;
    bus_if.pixIdx   = 4'd1;
    bus_if.aplha    = 1'b1;
    bus_if.mode_rtr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mode_q.push_back(3'd4);
      color_q.push_back(COL_A);
      pix_q.push_back({8'd186, 8'd143, 8'd125, 8'hFF});
      @(posedge sclk);
      #1;
    end
    bus_if.mode_rtr = 1'b0;
    repeat (4) @(posedge sclk);
    #1;

    // Reset one cycle after the request: mode is already out, nothing further may follow.
    bus_if.block    = BLK_A;
    bus_if.pixIdx   = 4'd0;
    bus_if.mode_rtr = 1'b1;
    mode_q.push_back(3'd4);
    @(posedge sclk);
    #1;
    bus_if.mode_rtr = 1'b0;
    rsrt            = 1'b1;
    @(posedge sclk);
    #1;
    rsrt = 1'b0;
    check_idle("midreset");
    repeat (6) @(posedge sclk);
    #1;

    chk("mode_q_drained", 72'(mode_q.size()), 72'd0);
    chk("color_q_drained", 72'(color_q.size()), 72'd0);
    chk("pix_q_drained", 72'(pix_q.size()), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
